frame_update_scheduler: RTL and testbench

Per-frame sequencer for the game-logic datapath. On each `frame_end` pulse from `sync_generator` it runs the logic units one at a time, lowest index first: player, dragon head, dragon body and spare. Each unit gets a one-cycle start strobe, and the scheduler waits for that unit's done handshake before moving to the next. Per-unit frame dividers set each unit's update rate, so the dragon can move every N frames. Watchdog, overrun and pause handling keep the frame loop deterministic.

---
 rtl/frame_update_scheduler.sv | 153 +++++++++++++++
 tb/tb_frame_update_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_update_scheduler.sv
// ============================================================================
// frame_update_scheduler
// Per-frame sequencer: strobes each due logic unit in priority order and waits
// for its done handshake, with per-unit frame dividers, a watchdog and
// sticky overrun / timeout flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module frame_update_scheduler #(
  parameter int NUM_UNITS = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_end,
  input  logic                     pause,
  input  logic                     clear_err,
  input  logic [NUM_UNITS-1:0]     unit_enable,
  input  logic [4*NUM_UNITS-1:0]   unit_divider,
  input  logic [NUM_UNITS-1:0]     unit_done,
  output logic [NUM_UNITS-1:0]     unit_start,
  output logic                     busy,
  output logic                     overrun,
  output logic [NUM_UNITS-1:0]     timeout_err,
  output logic [15:0]              frame_count
);

  localparam int IDXW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

  logic [1:0]                 r_state;
  logic [NUM_UNITS-1:0]       r_mask;
  logic [IDXW-1:0]            r_idx;
  logic [7:0]                 r_wdog;
  logic [NUM_UNITS-1:0][3:0]  r_divcnt;
  logic [15:0]                r_frame_count;
  logic                       r_overrun;
  logic [NUM_UNITS-1:0]       r_timeout_err;

  logic                       w_accept;
  logic                       w_overrun_set;
  logic [NUM_UNITS-1:0]       w_run;
  logic [NUM_UNITS-1:0]       w_idx_oh;
  logic [NUM_UNITS-1:0]       w_mask_rem;
  logic                       w_done;
  logic                       w_expired;
  logic                       w_finish;
  logic [NUM_UNITS-1:0]       w_tmo_set;

  function automatic logic [IDXW-1:0] f_lowest(input logic [NUM_UNITS-1:0] m);
    logic [IDXW-1:0] v;
    v = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (m[i]) v = IDXW'(i);
    end
    return v;
  endfunction

  assign w_accept      = frame_end & ~pause & (r_state == S_IDLE);
  assign w_overrun_set = frame_end & ~pause & (r_state != S_IDLE);
  assign w_idx_oh      = NUM_UNITS'(1) << r_idx;
  assign w_mask_rem    = r_mask & ~w_idx_oh;
  assign w_done        = unit_done[r_idx];
  assign w_expired     = (r_wdog == 8'd0);
  assign w_finish      = (r_state == S_WAIT) & (w_done | w_expired);
  // Done on the last watchdog cycle takes precedence over the timeout.
  assign w_tmo_set     = ((r_state == S_WAIT) & ~w_done & w_expired) ? w_idx_oh : '0;

  always_comb begin
    w_run = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      w_run[i] = unit_enable[i] & (r_divcnt[i] == 4'd0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_idx   <= '0;
      r_wdog  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mask <= w_run;
            if (|w_run) begin
              r_idx   <= f_lowest(w_run);
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_wdog  <= c_TIMEOUT;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_finish) begin
            r_mask <= w_mask_rem;
            if (|w_mask_rem) begin
              r_idx   <= f_lowest(w_mask_rem);
              r_state <= S_ISSUE;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_wdog <= r_wdog - 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_count <= '0;
      r_overrun     <= 1'b0;
      r_timeout_err <= '0;
    end else begin
      if (w_accept) r_frame_count <= r_frame_count + 16'd1;
      r_overrun     <= (r_overrun & ~clear_err) | w_overrun_set;
      r_timeout_err <= (r_timeout_err & ~{NUM_UNITS{clear_err}}) | w_tmo_set;
    end
  end

  // A zero counter means the unit is due this frame; it then reloads its period.
  for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_div
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_divcnt[gi] <= 4'd0;
      end else if (w_accept) begin
        if (r_divcnt[gi] == 4'd0) r_divcnt[gi] <= unit_divider[4*gi +: 4];
        else                      r_divcnt[gi] <= r_divcnt[gi] - 4'd1;
      end
    end
  end

  assign unit_start  = (r_state == S_ISSUE) ? w_idx_oh : '0;
  assign busy        = (r_state != S_IDLE);
  assign overrun     = r_overrun;
  assign timeout_err = r_timeout_err;
  assign frame_count = r_frame_count;

endmodule

`default_nettype wire

// File: tb/tb_frame_update_scheduler.sv
// ============================================================================
// tb_frame_update_scheduler
// Directed checks of sequencing, dividers, watchdog, overrun, pause and reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_frame_update_scheduler;

  localparam int N   = 4;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_end;
  logic          pause;
  logic          clear_err;
  logic [N-1:0]  unit_enable;
  logic [4*N-1:0] unit_divider;
  logic [N-1:0]  unit_done;
  logic [N-1:0]  unit_start;
  logic          busy;
  logic          overrun;
  logic [N-1:0]  timeout_err;
  logic [15:0]   frame_count;

  frame_update_scheduler #(.NUM_UNITS(N), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_end    (frame_end),
    .pause        (pause),
    .clear_err    (clear_err),
    .unit_enable  (unit_enable),
    .unit_divider (unit_divider),
    .unit_done    (unit_done),
    .unit_start   (unit_start),
    .busy         (busy),
    .overrun      (overrun),
    .timeout_err  (timeout_err),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int resp_dly[N];
  int resp_cnt[N];

  typedef struct {
    logic       fe;
    logic [3:0] exp_start;
    logic       exp_busy;
  } vec_t;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic fe, input logic pa, input logic ce);
    @(posedge clk);
    #1;
    frame_end = fe;
    pause     = pa;
    clear_err = ce;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset = 1'b1; frame_end = 1'b0; pause = 1'b0; clear_err = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One accepted frame; optionally pulses frame_end mid-sequence at step inj.
  task automatic run_frame(input int inj, input logic inj_pause, output logic [3:0] seen);
    int  n;
    bit  fin;
    seen = '0;
    n    = 0;
    fin  = 0;
    cyc(1'b1, 1'b0, 1'b0);
    while (!fin) begin
      cyc((n == inj), (n == inj) ? inj_pause : 1'b0, 1'b0);
      seen = seen | unit_start;
      if (!busy) fin = 1;
      n++;
      if (n > 300) begin
        n_tests++; n_fail++;
        $display("FAIL frame_budget: busy still %0b after %0d cycles, required 0", busy, n);
        fin = 1;
      end
    end
  endtask

  task automatic wait_start(input int u);
    int n;
    n = 0;
    do begin
      cyc(1'b0, 1'b0, 1'b0);
      n++;
    end while (!unit_start[u] && n < 100);
    if (!unit_start[u]) begin
      n_tests++; n_fail++;
      $display("FAIL wait_start%0d: start never seen, got %0h required bit %0d", u, unit_start, u);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      cyc(1'b0, 1'b0, 1'b0);
      n++;
    end
    if (busy) begin
      n_tests++; n_fail++;
      $display("FAIL wait_idle: busy got 1 required 0");
    end
  endtask

  // Unit model: done pulses resp_dly cycles after its start; 0 means never.
  initial begin
    unit_done = '0;
    for (int i = 0; i < N; i++) resp_cnt[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      unit_done = '0;
      for (int i = 0; i < N; i++) begin
        if (unit_start[i]) begin
          resp_cnt[i] = resp_dly[i];
        end else if (resp_cnt[i] > 0) begin
          resp_cnt[i]--;
          if (resp_cnt[i] == 0) unit_done[i] = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    vec_t        tbl[15];
    logic [3:0]  seen;
    logic [3:0]  exp_seen;
    logic [15:0] fc0;

    reset = 1'b1; frame_end = 1'b0; pause = 1'b0; clear_err = 1'b0;
    unit_enable = 4'b1011; unit_divider = '0;
    for (int i = 0; i < N; i++) resp_dly[i] = 3;

    for (int j = 0; j < 15; j++) begin
      tbl[j].fe        = (j == 0);
      tbl[j].exp_start = 4'b0000;
      tbl[j].exp_busy  = (j >= 1 && j <= 12);
    end
    tbl[1].exp_start = 4'b0001;
    tbl[5].exp_start = 4'b0010;
    tbl[9].exp_start = 4'b1000;

    @(posedge clk);
    #1;
    chk("rst_start", 16'(unit_start), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_overrun", 16'(overrun), 16'h0);
    chk("rst_tmo", 16'(timeout_err), 16'h0);
    chk("rst_fc", frame_count, 16'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);

    // Basic sequencing, cycle by cycle
    for (int j = 0; j < 15; j++) begin
      cyc(tbl[j].fe, 1'b0, 1'b0);
      chk($sformatf("seq_start[%0d]", j), 16'(unit_start), 16'(tbl[j].exp_start));
      chk($sformatf("seq_busy[%0d]", j), 16'(busy), 16'(tbl[j].exp_busy));
    end
    chk("seq_fc", frame_count, 16'd1);

    // Divider: unit1 every third frame
    unit_enable = 4'b1111; unit_divider = 16'h0020;
    for (int f = 0; f < 7; f++) begin
      run_frame(-1, 1'b0, seen);
      exp_seen = (f % 3 == 0) ? 4'b1111 : 4'b1101;
      chk($sformatf("div_frame%0d", f + 1), 16'(seen), 16'(exp_seen));
    end
    chk("div_fc", frame_count, 16'd8);

    // Watchdog: unit2 hangs
    apply_reset();
    unit_divider = '0;
    resp_dly[2] = 0;
    cyc(1'b1, 1'b0, 1'b0);
    wait_start(2);
    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    chk("wd_k5_tmo", 16'(timeout_err), 16'h0);
    chk("wd_k5_start", 16'(unit_start), 16'h0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("wd_k6_tmo", 16'(timeout_err), 16'h4);
    chk("wd_k6_start", 16'(unit_start), 16'h8);
    wait_idle();

    // Watchdog boundary: done on the last allowed cycle
    resp_dly[2] = 5;
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("clr_tmo", 16'(timeout_err), 16'h0);
    cyc(1'b1, 1'b0, 1'b0);
    wait_start(2);
    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    chk("wdb_k5_start", 16'(unit_start), 16'h0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("wdb_k6_tmo", 16'(timeout_err), 16'h0);
    chk("wdb_k6_start", 16'(unit_start), 16'h8);
    wait_idle();

    // Overrun
    resp_dly[2] = 3;
    fc0 = frame_count;
    run_frame(4, 1'b0, seen);
    chk("ovr_seen", 16'(seen), 16'hf);
    chk("ovr_flag", 16'(overrun), 16'h1);
    chk("ovr_fc", frame_count, fc0 + 16'd1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("ovr_clear", 16'(overrun), 16'h0);
    run_frame(4, 1'b1, seen);
    chk("pause_mid_seen", 16'(seen), 16'hf);
    chk("pause_mid_ovr", 16'(overrun), 16'h0);

    // Pause freezes frame counting and divider phase
    unit_divider = 16'h0030;
    run_frame(-1, 1'b0, seen);
    chk("pz_A", 16'(seen), 16'hf);
    run_frame(-1, 1'b0, seen);
    chk("pz_B", 16'(seen), 16'hd);
    fc0 = frame_count;
    for (int p = 0; p < 3; p++) begin
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      chk($sformatf("pz_start%0d", p), 16'(unit_start), 16'h0);
      chk($sformatf("pz_busy%0d", p), 16'(busy), 16'h0);
    end
    chk("pz_fc", frame_count, fc0);
    chk("pz_ovr", 16'(overrun), 16'h0);
    run_frame(-1, 1'b0, seen);
    chk("pz_C", 16'(seen), 16'hd);
    run_frame(-1, 1'b0, seen);
    chk("pz_D", 16'(seen), 16'hd);
    run_frame(-1, 1'b0, seen);
    chk("pz_E", 16'(seen), 16'hf);

    // Reset mid-sequence with flags set
    resp_dly[0] = 0;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    wait_start(2);
    chk("mr_pre_tmo", 16'(timeout_err), 16'h1);
    chk("mr_pre_ovr", 16'(overrun), 16'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("mr_start", 16'(unit_start), 16'h0);
    chk("mr_busy", 16'(busy), 16'h0);
    chk("mr_ovr", 16'(overrun), 16'h0);
    chk("mr_tmo", 16'(timeout_err), 16'h0);
    chk("mr_fc", frame_count, 16'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    resp_dly[0] = 3;
    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    run_frame(-1, 1'b0, seen);
    chk("mr_after_seen", 16'(seen), 16'hf);
    chk("mr_after_fc", frame_count, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
